// File: rtl/icefun_led_framebuffer_pkg.sv
// Shared constants, bus request type and byte-strobe helper for the iceFUN LED framebuffer.
// The optional PWM dimming path is enabled with ICEFUN_LEDFB_PWM_EN.
package icefun_led_framebuffer_pkg;

  localparam int unsigned LEDFB_DATA_W = 32;
  localparam int unsigned LEDFB_ADDR_W = 2;
  localparam int unsigned LEDFB_STRB_W = LEDFB_DATA_W / 8;
  localparam int unsigned LEDFB_FCNT_W = 8;

  localparam logic [LEDFB_ADDR_W-1:0] LEDFB_ADDR_BACK   = 2'd0;
  localparam logic [LEDFB_ADDR_W-1:0] LEDFB_ADDR_CTRL   = 2'd1;
  localparam logic [LEDFB_ADDR_W-1:0] LEDFB_ADDR_STATUS = 2'd2;
  localparam logic [LEDFB_ADDR_W-1:0] LEDFB_ADDR_BRIGHT = 2'd3;

  localparam int unsigned LEDFB_CTRL_SWAP_BIT      = 0;
  localparam int unsigned LEDFB_STATUS_PENDING_BIT = 0;
  localparam int unsigned LEDFB_STATUS_FCNT_LSB    = 8;

  typedef struct packed {
    logic                    we;
    logic [LEDFB_ADDR_W-1:0] addr;
    logic [LEDFB_DATA_W-1:0] wdata;
    logic [LEDFB_STRB_W-1:0] wstrb;
  } ledfb_req_t;

  // Merge write data into an existing word, one byte per strobe bit.
  function automatic logic [LEDFB_DATA_W-1:0] ledfb_apply_wstrb(
    input logic [LEDFB_DATA_W-1:0] old_v,
    input logic [LEDFB_DATA_W-1:0] wdata,
    input logic [LEDFB_STRB_W-1:0] wstrb
  );
    logic [LEDFB_DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(LEDFB_STRB_W); i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/icefun_led_framebuffer_if.sv
// CPU-side register bus of the LED framebuffer: valid/ready request with one-cycle completion pulse.
// Shared by all builds, with or without ICEFUN_LEDFB_PWM_EN.
interface icefun_led_framebuffer_if;

  logic                                                  bus_valid;
  logic                                                  bus_we;
  logic [icefun_led_framebuffer_pkg::LEDFB_ADDR_W-1:0]   bus_addr;
  logic [icefun_led_framebuffer_pkg::LEDFB_DATA_W-1:0]   bus_wdata;
  logic [icefun_led_framebuffer_pkg::LEDFB_STRB_W-1:0]   bus_wstrb;
  logic                                                  bus_ready;
  logic [icefun_led_framebuffer_pkg::LEDFB_DATA_W-1:0]   bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata
  );

endinterface

// File: rtl/icefun_ledfb_pwm.sv
// Free-running PWM counter and brightness gate for the LED framebuffer.
// Only instantiated when ICEFUN_LEDFB_PWM_EN is defined.
module icefun_ledfb_pwm #(
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] bright_i,
  output logic                gate_o
);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                gate_q, gate_d;

  // Full brightness keeps the gate permanently open, zero keeps it closed.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    gate_d    = (pwm_cnt_q < bright_i) | (&bright_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      gate_q    <= 1'b1;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      gate_q    <= gate_d;
    end
  end

  assign gate_o = gate_q;

endmodule

// File: rtl/icefun_led_framebuffer.sv
// Double-buffered 4x8 LED bitmap: CPU writes the back buffer, swap to front happens on a frame tick.
// Define ICEFUN_LEDFB_PWM_EN to add the BRIGHT register and PWM dimming of the LED outputs.
module icefun_led_framebuffer
  import icefun_led_framebuffer_pkg::*;
#(
  parameter int unsigned FRAME_DIV = 14,
  parameter int unsigned PWM_BITS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  icefun_led_framebuffer_if.slave   bus,
  output logic [7:0]                leds1,
  output logic [7:0]                leds2,
  output logic [7:0]                leds3,
  output logic [7:0]                leds4,
  output logic                      frame_tick
);

  // The tick register is loaded one count early so it is high while the timer sits at all-ones.
  localparam logic [FRAME_DIV-1:0] TIMER_PRE = ~FRAME_DIV'(1);

  ledfb_req_t              req_c;
  logic                    access_c, wr_c, gate_c;
  logic [PWM_BITS-1:0]     bright_val;
  logic [LEDFB_DATA_W-1:0] status_c;

  logic [FRAME_DIV-1:0]    timer_q, timer_d;
  logic                    tick_q, tick_d;
  logic [LEDFB_FCNT_W-1:0] fcnt_q, fcnt_d;
  logic                    pend_q, pend_d;
  logic [LEDFB_DATA_W-1:0] back_q, back_d;
  logic [LEDFB_DATA_W-1:0] front_q, front_d;
  logic [LEDFB_DATA_W-1:0] leds_q, leds_d;
  logic                    ready_q, ready_d;
  logic [LEDFB_DATA_W-1:0] rdata_q, rdata_d;

  assign req_c = '{we: bus.bus_we, addr: bus.bus_addr, wdata: bus.bus_wdata, wstrb: bus.bus_wstrb};

  // A request is accepted only while ready is low, which forces at least two cycles per access.
  assign access_c = bus.bus_valid && !ready_q;
  assign wr_c     = access_c && req_c.we;

`ifdef ICEFUN_LEDFB_PWM_EN
  logic [PWM_BITS-1:0] bright_q, bright_d;

  always_comb begin
    bright_d = bright_q;
    if (wr_c && req_c.addr == LEDFB_ADDR_BRIGHT && req_c.wstrb[0]) begin
      bright_d = req_c.wdata[PWM_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bright_q <= '1;
    else     bright_q <= bright_d;
  end

  assign bright_val = bright_q;

  icefun_ledfb_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .bright_i (bright_q),
    .gate_o   (gate_c)
  );
`else
  assign bright_val = '0;
  assign gate_c     = 1'b1;
`endif

  always_comb begin
    status_c = '0;
    status_c[LEDFB_STATUS_PENDING_BIT] = pend_q;
    status_c[LEDFB_STATUS_FCNT_LSB +: LEDFB_FCNT_W] = fcnt_q;
  end

  // Next-state for timer, buffers, swap and bus response.
  always_comb begin
    timer_d = timer_q + FRAME_DIV'(1);
    tick_d  = (timer_q == TIMER_PRE);
    fcnt_d  = tick_q ? fcnt_q + LEDFB_FCNT_W'(1) : fcnt_q;
    back_d  = back_q;
    front_d = front_q;
    pend_d  = pend_q;
    ready_d = access_c;
    rdata_d = '0;
    leds_d  = front_q & {LEDFB_DATA_W{gate_c}};

    if (wr_c && req_c.addr == LEDFB_ADDR_BACK) begin
      back_d = ledfb_apply_wstrb(back_q, req_c.wdata, req_c.wstrb);
    end

    // Swap uses the pre-write back value; a CTRL write on the same edge re-arms for the next tick.
    if (tick_q && pend_q) begin
      front_d = back_q;
      pend_d  = 1'b0;
    end
    if (wr_c && req_c.addr == LEDFB_ADDR_CTRL && req_c.wdata[LEDFB_CTRL_SWAP_BIT]) begin
      pend_d = 1'b1;
    end

    if (access_c && !req_c.we) begin
      unique case (req_c.addr)
        LEDFB_ADDR_BACK:   rdata_d = back_q;
        LEDFB_ADDR_STATUS: rdata_d = status_c;
        LEDFB_ADDR_BRIGHT: rdata_d = LEDFB_DATA_W'(bright_val);
        default:           rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      tick_q  <= 1'b0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      back_q  <= '0;
      front_q <= '0;
      leds_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      timer_q <= timer_d;
      tick_q  <= tick_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      back_q  <= back_d;
      front_q <= front_d;
      leds_q  <= leds_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.bus_ready = ready_q;
  assign bus.bus_rdata = rdata_q;
  assign leds1         = leds_q[7:0];
  assign leds2         = leds_q[15:8];
  assign leds3         = leds_q[23:16];
  assign leds4         = leds_q[31:24];
  assign frame_tick    = tick_q;

endmodule
